// File: rtl/xmit_adapter.sv
// Transmit adapter: buffers one host frame, waits for a clear channel, then sends preamble/SFD/header/payload/CRC.
// Latency: first preamble byte valid 1 cycle after the clear-channel count completes; zero-bubble body streaming.
// Backpressure: mx_data/mx_valid advance only on mx_valid&&mx_rdy; host bytes arriving while busy are dropped and counted.
module xmit_adapter #(
   parameter int          BUF_DEPTH  = 256,
   parameter int          IFS_CYCLES = 80,
   parameter int          PRE_LEN    = 2,
   parameter logic [7:0]  SFD        = 8'hD0,
   parameter logic [7:0]  EOT        = 8'h04
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] mac_addr,
   input  logic [7:0] uart_data,
   input  logic       uart_valid,
   input  logic       cardet,
   input  logic       mx_rdy,
   output logic [7:0] mx_data,
   output logic       mx_valid,
   output logic       busy,
   output logic [7:0] xerrcnt,
   output logic [2:0] state
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(IFS_CYCLES + 1);
   localparam int PW = $clog2(PRE_LEN + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL      = 3'd1,
      WAIT_IFS  = 3'd2,
      SEND_PRE  = 3'd3,
      SEND_BODY = 3'd4,
      SEND_CRC  = 3'd5,
      DISCARD   = 3'd6
   } state_t;

   state_t          st;
   logic [7:0]      mem [BUF_DEPTH];
   logic [LW-1:0]   len;
   logic [LW-1:0]   pos;
   logic [PW-1:0]   pre_idx;
   logic [CW-1:0]   clr_cnt;
   logic [7:0]      crc;

   logic            is_eot;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic            accept;
   logic [7:0]      next_body;
   logic [7:0]      crc_nxt;
   logic            crc_frame;

   // CRC-8, polynomial 0x07, MSB first, one byte per call
   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      end
      return r;
   endfunction

   assign state   = st;
   assign is_eot  = (uart_data == EOT);
   assign accept  = mx_valid && mx_rdy;
   assign wr_en   = uart_valid && !is_eot &&
                    ((st == IDLE) || ((st == FILL) && (len != LW'(BUF_DEPTH))));
   assign wr_addr = (st == IDLE) ? '0 : len[AW-1:0];
   // Body order is buf[0], mac, buf[1..]; for positions >= 2 the buffer index
   // of the following byte equals the current position.
   assign next_body = (pos == '0) ? mac_addr : mem[pos[AW-1:0]];
   assign crc_nxt   = crc8(crc, mx_data);
   assign crc_frame = (mem[1] == 8'h31);

   // Frame buffer write port; contents need no reset since len gates reads
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= uart_data;
      end
   end

   // Main FSM: host fill, clear-channel wait and byte streaming
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         len      <= '0;
         pos      <= '0;
         pre_idx  <= '0;
         clr_cnt  <= '0;
         crc      <= '0;
         mx_data  <= '0;
         mx_valid <= 1'b0;
         busy     <= 1'b0;
         xerrcnt  <= '0;
      end else begin
         if (uart_valid && busy) begin
            xerrcnt <= xerrcnt + 8'd1;
         end
         case (st)
            IDLE: begin
               len     <= '0;
               clr_cnt <= '0;
               if (uart_valid && !is_eot) begin
                  len <= LW'(1);
                  st  <= FILL;
               end
            end
            FILL: begin
               if (uart_valid) begin
                  if (is_eot) begin
                     if (len >= LW'(2)) begin
                        st      <= WAIT_IFS;
                        busy    <= 1'b1;
                        clr_cnt <= '0;
                     end else begin
                        xerrcnt <= xerrcnt + 8'd1;
                        st      <= IDLE;
                     end
                  end else if (len == LW'(BUF_DEPTH)) begin
                     xerrcnt <= xerrcnt + 8'd1;
                     st      <= DISCARD;
                  end else begin
                     len <= len + LW'(1);
                  end
               end
            end
            DISCARD: begin
               if (uart_valid && is_eot) begin
                  st <= IDLE;
               end
            end
            WAIT_IFS: begin
               if (clr_cnt == CW'(IFS_CYCLES)) begin
                  st       <= SEND_PRE;
                  mx_valid <= 1'b1;
                  mx_data  <= 8'h55;
                  pre_idx  <= '0;
                  crc      <= '0;
                  pos      <= '0;
               end else if (cardet) begin
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + CW'(1);
               end
            end
            SEND_PRE: begin
               if (accept) begin
                  if (pre_idx < PW'(PRE_LEN - 1)) begin
                     mx_data <= 8'h55;
                     pre_idx <= pre_idx + PW'(1);
                  end else if (pre_idx == PW'(PRE_LEN - 1)) begin
                     mx_data <= SFD;
                     pre_idx <= pre_idx + PW'(1);
                  end else begin
                     st      <= SEND_BODY;
                     mx_data <= mem[0];
                     pos     <= '0;
                  end
               end
            end
            SEND_BODY: begin
               if (accept) begin
                  crc <= crc_nxt;
                  if (pos == len) begin
                     if (crc_frame) begin
                        st      <= SEND_CRC;
                        mx_data <= crc_nxt;
                     end else begin
                        st       <= IDLE;
                        mx_valid <= 1'b0;
                        busy     <= 1'b0;
                     end
                  end else begin
                     pos     <= pos + LW'(1);
                     mx_data <= next_body;
                  end
               end
            end
            SEND_CRC: begin
               if (accept) begin
                  st       <= IDLE;
                  mx_valid <= 1'b0;
                  busy     <= 1'b0;
               end
            end
            default: begin
               st       <= IDLE;
               mx_valid <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xmit_adapter.sv
// Testbench for xmit_adapter: table of host frames with expected wire bytes,
// plus directed sequences for carrier deferral, overflow, busy drops and reset.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_xmit_adapter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] mac_addr;
   logic [7:0] uart_data;
   logic       uart_valid;
   logic       cardet;
   logic       mx_rdy;
   logic [7:0] mx_data;
   logic       mx_valid;
   logic       busy;
   logic [7:0] xerrcnt;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   logic       rdy_rand = 1'b0;
   logic [7:0] rx_q [$];
   logic [7:0] xbase;

   typedef struct packed {
      logic [7:0]        mac;
      logic [7:0]        nh;
      logic [0:7][7:0]   host;
      logic [7:0]        ntx;
      logic [0:11][7:0]  tx;
      logic [7:0]        xinc;
      logic              rnd;
   } vec_t;

   vec_t vecs [6];

   xmit_adapter dut (
      .clk        (clk),
      .rst        (rst),
      .mac_addr   (mac_addr),
      .uart_data  (uart_data),
      .uart_valid (uart_valid),
      .cardet     (cardet),
      .mx_rdy     (mx_rdy),
      .mx_data    (mx_data),
      .mx_valid   (mx_valid),
      .busy       (busy),
      .xerrcnt    (xerrcnt),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      uart_data  = b;
      uart_valid = 1'b1;
      tick();
      uart_valid = 1'b0;
   endtask

   task automatic begin_frame(input logic [7:0] mac, input logic rnd);
      mac_addr = mac;
      rdy_rand = rnd;
      rx_q.delete();
      xbase = xerrcnt;
   endtask

   task automatic wait_state(input logic [2:0] s, input string name);
      int n = 0;
      while (state !== s && n < 2000) begin
         tick();
         n++;
      end
      chk(name, 32'(state), 32'(s));
   endtask

   // Wait for the adapter to go quiet, then compare captured wire bytes
   task automatic finish_frame(input vec_t v, input string name);
      int n = 0;
      logic [7:0] d;
      while (!(state === 3'd0 && mx_valid === 1'b0) && n < 3000) begin
         tick();
         n++;
      end
      rdy_rand = 1'b0;
      repeat (3) tick();
      chk({name, " end_state"}, 32'(state), 32'd0);
      chk({name, " busy_low"}, 32'(busy), 32'd0);
      chk({name, " tx_count"}, 32'(rx_q.size()), 32'(v.ntx));
      for (int i = 0; i < int'(v.ntx); i++) begin
         if (i < rx_q.size())
            chk($sformatf("%s byte%0d", name, i), 32'(rx_q[i]), 32'(v.tx[i]));
      end
      d = xerrcnt - xbase;
      chk({name, " xerr_delta"}, 32'(d), 32'(v.xinc));
   endtask

   task automatic run_vec(input vec_t v, input string name);
      begin_frame(v.mac, v.rnd);
      for (int i = 0; i < int'(v.nh); i++) send_byte(v.host[i]);
      finish_frame(v, name);
   endtask

   // Ready driver: constant high, or random while a stalling vector runs
   initial begin
      mx_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         mx_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Wire monitor: capture accepted bytes, check hold stability while stalled
   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (prev_stall && !rst)
            chk("stall_hold", {23'b0, mx_valid, mx_data}, {23'b0, 1'b1, prev_data});
         if (mx_valid && mx_rdy && !rst) rx_q.push_back(mx_data);
         prev_stall = mx_valid && !mx_rdy;
         prev_data  = mx_data;
      end
   end

   initial begin
      #800000;
      $display("FAIL global_timeout: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      logic quiet;
      logic [7:0] d;

      vecs[0] = '{mac:8'h12, nh:8'd5, host:{8'h2A,8'h30,8'h41,8'h42,8'h04,24'h0},
                  ntx:8'd8, tx:{8'h55,8'h55,8'hD0,8'h2A,8'h12,8'h30,8'h41,8'h42,32'h0},
                  xinc:8'd0, rnd:1'b0};
      vecs[1] = '{mac:8'h00, nh:8'd3, host:{8'h00,8'h31,8'h04,40'h0},
                  ntx:8'd7, tx:{8'h55,8'h55,8'hD0,8'h00,8'h00,8'h31,8'h97,40'h0},
                  xinc:8'd0, rnd:1'b0};
      vecs[2] = '{mac:8'h12, nh:8'd2, host:{8'h2A,8'h04,48'h0},
                  ntx:8'd0, tx:96'h0, xinc:8'd1, rnd:1'b0};
      vecs[3] = '{mac:8'h34, nh:8'd1, host:{8'h04,56'h0},
                  ntx:8'd0, tx:96'h0, xinc:8'd0, rnd:1'b0};
      vecs[4] = '{mac:8'h5C, nh:8'd5, host:{8'h7E,8'h10,8'h00,8'hFF,8'h04,24'h0},
                  ntx:8'd8, tx:{8'h55,8'h55,8'hD0,8'h7E,8'h5C,8'h10,8'h00,8'hFF,32'h0},
                  xinc:8'd0, rnd:1'b1};
      vecs[5] = '{mac:8'h00, nh:8'd4, host:{8'h00,8'h31,8'h00,8'h04,32'h0},
                  ntx:8'd8, tx:{8'h55,8'h55,8'hD0,8'h00,8'h00,8'h31,8'h00,8'hEC,32'h0},
                  xinc:8'd0, rnd:1'b1};

      rst        = 1'b1;
      mac_addr   = 8'h00;
      uart_data  = 8'h00;
      uart_valid = 1'b0;
      cardet     = 1'b0;
      xbase      = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset state", 32'(state), 32'd0);
      chk("reset mx_valid", 32'(mx_valid), 32'd0);
      chk("reset mx_data", 32'(mx_data), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset xerrcnt", 32'(xerrcnt), 32'd0);
      rst = 1'b0;
      tick();

      for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // Carrier deferral: held busy channel, then a pulse restarts the count
      v = '{mac:8'h12, nh:8'd0, host:64'h0,
            ntx:8'd7, tx:{8'h55,8'h55,8'hD0,8'h2A,8'h12,8'h30,8'h41,40'h0},
            xinc:8'd0, rnd:1'b0};
      cardet = 1'b1;
      begin_frame(8'h12, 1'b0);
      send_byte(8'h2A); send_byte(8'h30); send_byte(8'h41); send_byte(8'h04);
      repeat (500) tick();
      chk("cardet hold state", 32'(state), 32'd2);
      chk("cardet hold no tx", 32'(rx_q.size()), 32'd0);
      cardet = 1'b0;
      repeat (50) tick();
      cardet = 1'b1;
      tick();
      cardet = 1'b0;
      quiet = 1'b1;
      repeat (80) begin
         tick();
         if (mx_valid) quiet = 1'b0;
      end
      chk("cardet quiet 80", 32'(quiet), 32'd1);
      tick();
      chk("cardet first valid", 32'(mx_valid), 32'd1);
      chk("cardet first byte", 32'(mx_data), 32'h55);
      finish_frame(v, "cardet");

      // Overflow: 257 data bytes are discarded, then a normal frame goes out
      begin_frame(8'h12, 1'b0);
      for (int i = 0; i < 257; i++) send_byte(8'h10);
      send_byte(8'h04);
      chk("ovf state", 32'(state), 32'd0);
      repeat (150) tick();
      chk("ovf no tx", 32'(rx_q.size()), 32'd0);
      d = xerrcnt - xbase;
      chk("ovf xerr", 32'(d), 32'd1);
      v = '{mac:8'h12, nh:8'd3, host:{8'h2A,8'h30,8'h04,40'h0},
            ntx:8'd6, tx:{8'h55,8'h55,8'hD0,8'h2A,8'h12,8'h30,48'h0},
            xinc:8'd0, rnd:1'b0};
      run_vec(v, "post_ovf");

      // Host bytes during SEND_BODY are counted and dropped
      v = vecs[0];
      v.xinc = 8'd2;
      begin_frame(8'h12, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(v.host[i]);
      wait_state(3'd4, "busy reach body");
      send_byte(8'h99);
      d = xerrcnt - xbase;
      chk("busy xerr next cycle", 32'(d), 32'd1);
      send_byte(8'h04);
      finish_frame(v, "busy_drop");

      // Reset in the middle of the body
      begin_frame(8'h12, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(vecs[0].host[i]);
      wait_state(3'd4, "rst reach body");
      rst = 1'b1;
      tick();
      chk("rst mx_valid", 32'(mx_valid), 32'd0);
      chk("rst state", 32'(state), 32'd0);
      chk("rst xerrcnt", 32'(xerrcnt), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      rst = 1'b0;
      rx_q.delete();
      repeat (200) tick();
      chk("rst no residual", 32'(rx_q.size()), 32'd0);
      chk("rst idle after", 32'(state), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xmit_adapter.md
# xmit_adapter

Transmit-side adapter for the WimpFi link. It accepts frame bytes from the UART receiver, buffers one complete frame internally, and waits for a clear channel. It then streams preamble, SFD, header (with this station's MAC inserted as source), payload and an optional CRC-8 byte to the Manchester transmitter over a valid/ready handshake. The frames it produces are the ones the receive-side adapter of the same design accepts.

## Interface
- BUF_DEPTH, 256: frame buffer depth in bytes, power of two, max stored host bytes (dest+type+data).
- IFS_CYCLES, 80: consecutive clk cycles with cardet low required before transmission.
- PRE_LEN, 2: number of 0x55 preamble bytes.
- SFD, 8'hD0: start-of-frame delimiter byte.
- EOT, 8'h04: host end-of-frame marker (never stored or sent).
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high.
- mac_addr  in  8  this station's address, inserted as source byte.
- uart_data  in  8  byte from UART receiver.
- uart_valid  in  1  one-cycle strobe, uart_data valid.
- cardet  in  1  carrier detect from Manchester receiver.
- mx_rdy  in  1  Manchester transmitter can accept a byte.
- mx_data  out  8  byte to transmit.
- mx_valid  out  1  mx_data valid.
- busy  out  1  high in WAIT_IFS, SEND_PRE, SEND_BODY, SEND_CRC.
- xerrcnt  out  8  dropped-frame/byte error count, wraps 255->0.
- state  out  3  current FSM state encoding.

## Operation
- Host frame: dest, type, data[0..n], EOT. Transmitted frame: PRE_LEN x 0x55, SFD, dest, mac_addr, type, data..., CRC (only if type==8'h31).
- A data byte equal to EOT cannot be sent; this is a documented limitation.
- CRC-8: poly 0x07, init 0x00, MSB-first, no final XOR. It covers dest, src, type and data, in transmit order. It excludes preamble and SFD. The CRC is updated on each accepted body byte.
- States: IDLE=0, FILL=1, WAIT_IFS=2, SEND_PRE=3, SEND_BODY=4, SEND_CRC=5, DISCARD=6.
- IDLE: length counter cleared. A uart_valid with a non-EOT byte stores the byte and moves to FILL. A uart_valid with EOT is ignored.
- FILL: each non-EOT byte is stored at index len, then len increments.
  - EOT with len>=2 -> WAIT_IFS.
  - EOT with len<2 -> xerrcnt++, IDLE.
  - A non-EOT byte arriving when len==BUF_DEPTH -> xerrcnt++, DISCARD.
- DISCARD: all bytes are dropped until EOT, then IDLE.
- WAIT_IFS: the clear counter increments each cycle cardet==0 and clears on any cycle cardet==1. When the counter reaches IFS_CYCLES -> SEND_PRE, and the CRC register and read index are cleared.
- SEND_PRE: sends PRE_LEN x 0x55, then SFD -> SEND_BODY. cardet is ignored from SEND_PRE onward.
- SEND_BODY: sends buf[0], then mac_addr, then buf[1..len-1].
  - After the last byte is accepted: type==0x31 -> SEND_CRC, else IDLE.
- SEND_CRC: sends the CRC register value; on acceptance -> IDLE.
- uart_valid while busy: the byte is dropped and xerrcnt++. The buffered frame is unaffected.
- Reset values: state=IDLE, mx_valid=0, mx_data=0, busy=0, xerrcnt=0, len=0, CRC=0, clear counter=0.
- rst mid-transmission: aborts immediately. mx_valid=0 on the next cycle and the buffer contents are discarded.

## Timing
- All outputs are registered.
- mx_valid/mx_data change only on acceptance, i.e. a cycle with mx_valid&&mx_rdy. mx_data holds stable while mx_valid&&!mx_rdy.
- After acceptance, the next byte is presented with mx_valid high no later than 2 cycles later. A 1-cycle bubble is permitted for buffer read latency.
- First preamble byte: mx_valid rises 1 cycle after the clear counter reaches IFS_CYCLES.
- uart_valid arrives at most once per cycle and is handled in that cycle. Transitions FILL->WAIT_IFS and IDLE->FILL are visible on `state` 1 cycle after the strobe.
- xerrcnt increments 1 cycle after the triggering event.

## Test plan
- mac_addr=0x12; host 0x2A,0x30,0x41,0x42,0x04; cardet=0, mx_rdy=1 -> mx bytes 55 55 D0 2A 12 30 41 42, no CRC, then IDLE; busy low after last.
- mac_addr=0x00; host 0x00,0x31,0x04 -> 55 55 D0 00 00 31 97 (CRC 0x97), IDLE.
- cardet held high 500 cycles after EOT, pulsed high once at clear count 50 -> no mx_valid until 80 consecutive low cycles after the pulse.
- Host sends 257 non-EOT bytes then EOT -> no transmission, xerrcnt=1, state returns IDLE; a following valid frame is sent normally.
- Host 0x2A,0x04 -> xerrcnt=1, nothing sent. mx_rdy toggled randomly during a frame -> byte order is intact and mx_data is stable while stalled. Bytes arriving during SEND_BODY -> xerrcnt increments per byte and the frame is intact.
- rst asserted mid SEND_BODY -> next cycle mx_valid=0, state=IDLE, xerrcnt=0; no residual bytes after release.
